// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI transaction manager.
// The 4KB helper is only referenced when APB2AXI_4KB_CHECK_EN is defined.
package apb2axi_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned TAG_W      = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic                  is_write;
    } directory_entry_t;

    typedef enum logic {S_IDLE, S_ISSUE} txn_state_e;

    // Largest span is 256 beats << 7 = 32 KiB, so 17 bits hold offset + span.
    function automatic logic crosses_4kb(directory_entry_t e);
        logic [16:0] span;
        span = ({9'd0, e.len} + 17'd1) << e.size;
        return ({5'd0, e.addr[11:0]} + span) > 17'd4096;
    endfunction

endpackage

// File: rtl/apb2axi_credit_cnt.sv
// Per-direction outstanding counter: increments on issue, decrements on completion,
// flags a completion that arrives with nothing outstanding.
module apb2axi_credit_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign count     = count_q;
    assign full      = (count_q >= CNT_W'(MAX_OUTSTANDING));
    assign underflow = dec && !inc && (count_q == '0);

endmodule

// File: rtl/apb2axi_txn_mgr.sv
// Pops directory descriptors and issues one AXI AR/AW beat each, gated by per-direction credit.
// Optional APB2AXI_4KB_CHECK_EN drops descriptors that would cross a 4KB boundary.
module apb2axi_txn_mgr
    import apb2axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W      = apb2axi_pkg::AXI_ADDR_W,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  dir_pending_valid,
    input  directory_entry_t      dir_pending_entry,
    input  logic [TAG_W-1:0]      dir_pending_tag,
    output logic                  dir_pending_pop,
    output logic [TAG_W-1:0]      m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [TAG_W-1:0]      m_axi_awid,
    output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    input  logic                  rd_cpl_valid,
    input  logic                  wr_cpl_valid,
    output logic [CNT_W-1:0]      rd_outstanding,
    output logic [CNT_W-1:0]      wr_outstanding,
    output logic                  cpl_err,
    output logic                  busy
);

    txn_state_e            state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic                  is_write_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  cpl_err_q;

    logic rd_full, wr_full, rd_uf, wr_uf;
    logic credit_ok, viol, take, issue, handshake;

`ifdef APB2AXI_4KB_CHECK_EN
    assign viol = crosses_4kb(dir_pending_entry);
`else
    assign viol = 1'b0;
`endif

    // Credit uses the pre-update count; a violating entry is dropped regardless of credit.
    assign credit_ok = dir_pending_entry.is_write ? !wr_full : !rd_full;
    assign take      = (state_q == S_IDLE) && dir_pending_valid && (viol || credit_ok);
    assign issue     = take && !viol;
    assign handshake = (state_q == S_ISSUE) && (is_write_q ? m_axi_awready : m_axi_arready);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (issue)     state_d = S_ISSUE;
            S_ISSUE: if (handshake) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dir_pending_pop = take;
        m_axi_arvalid   = (state_q == S_ISSUE) && !is_write_q;
        m_axi_awvalid   = (state_q == S_ISSUE) && is_write_q;
        busy            = (state_q != S_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            is_write_q <= 1'b0;
            tag_q      <= '0;
        end else if (issue) begin
            addr_q     <= AXI_ADDR_W'(dir_pending_entry.addr);
            len_q      <= dir_pending_entry.len;
            size_q     <= dir_pending_entry.size;
            is_write_q <= dir_pending_entry.is_write;
            tag_q      <= dir_pending_tag;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cpl_err_q <= 1'b0;
        end else if (rd_uf || wr_uf || (take && viol)) begin
            cpl_err_q <= 1'b1;
        end
    end

    apb2axi_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_rd_cnt (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .inc       (handshake && !is_write_q),
        .dec       (rd_cpl_valid),
        .count     (rd_outstanding),
        .full      (rd_full),
        .underflow (rd_uf)
    );

    apb2axi_credit_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_wr_cnt (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .inc       (handshake && is_write_q),
        .dec       (wr_cpl_valid),
        .count     (wr_outstanding),
        .full      (wr_full),
        .underflow (wr_uf)
    );

    assign m_axi_arid    = tag_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_awid    = tag_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = size_q;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign cpl_err       = cpl_err_q;

endmodule
